// File: rtl/scan_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : scan_pkg
//  Description : Shared constants, digit type and index-width helper for the
//                digit scanner and its prescaler.
//  Revision    : 1.0 - initial release
// ============================================================================
package scan_pkg;

  // Default build: four digits, one digit slot every 50000 clocks.
  localparam int N_DIGITS_DEF = 4;
  localparam int PRESCALE_DEF = 50000;

  // One 4-bit code as consumed by the downstream 7-segment decoder.
  typedef logic [3:0] digit_t;

  // Width needed to count 0..n-1; never narrower than one bit so a
  // degenerate count of 1 still yields a legal vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/scan_tick.sv
`default_nettype none
// ============================================================================
//  Module      : scan_tick
//  Description : Digit-slot prescaler. Counts 0..PRESCALE-1 and wraps; oTick
//                is high during the final count of each slot, so the digit
//                index advances on the edge that ends the slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_tick
  import scan_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEF
) (
  input  logic iClk,
  input  logic iRst,
  output logic oTick
);

  localparam int            CW     = idx_width(PRESCALE);
  localparam logic [CW-1:0] C_LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          w_last;

  // The slot ends on the last count; that same cycle reloads zero.
  assign w_last = (count_q == C_LAST);
  assign oTick  = w_last;

  // Next count: wrap to zero after the last count, otherwise increment.
  always_comb begin
    count_d = count_q + CW'(1);
    if (w_last) begin
      count_d = '0;
    end
  end

  // Count register; reset restarts the slot so the first tick lands
  // exactly PRESCALE cycles after reset is released.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/digit_scan.sv
`default_nettype none
// ============================================================================
//  Module      : digit_scan
//  Description : Time-multiplexed digit scanner feeding a 4-bit-to-7-segment
//                decoder. Holds an N-digit code word, presents one digit per
//                slot on oW/oX/oY/oZ with a matching one-hot enable on oAn,
//                and applies newly loaded words only at the frame boundary.
//                Optional build macro DIGIT_SCAN_LZB_EN enables leading-zero
//                blanking of the digit enables (digit 0 is never blanked).
//  Revision    : 1.0 - initial release
// ============================================================================
module digit_scan
  import scan_pkg::*;
#(
  parameter int N_DIGITS = N_DIGITS_DEF,
  parameter int PRESCALE = PRESCALE_DEF
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iLoad,
  input  logic [4*N_DIGITS-1:0] iValue,
  output logic                  oW,
  output logic                  oX,
  output logic                  oY,
  output logic                  oZ,
  output logic [N_DIGITS-1:0]   oAn,
  output logic                  oFrame,
  output logic                  oPending
);

  localparam int                  IW         = idx_width(N_DIGITS);
  localparam logic [IW-1:0]       C_LAST_IDX = IW'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] C_AN_RST   = N_DIGITS'(1);

  // Slot timing.
  logic                         w_tick;
  logic                         w_wrap;

  // Scan index and code-word storage.
  logic [IW-1:0]                idx_q;
  logic [IW-1:0]                idx_d;
  digit_t [N_DIGITS-1:0]        disp_q;
  digit_t [N_DIGITS-1:0]        disp_d;
  digit_t [N_DIGITS-1:0]        pend_q;
  digit_t [N_DIGITS-1:0]        pend_d;
  logic                         flag_q;
  logic                         flag_d;

  // Registered outputs, computed from next-state so they move on the same
  // edge as the index itself.
  digit_t                       code_q;
  digit_t                       code_d;
  logic [N_DIGITS-1:0]          an_q;
  logic [N_DIGITS-1:0]          an_d;
  logic                         frame_q;
  logic                         frame_d;

  logic [N_DIGITS-1:0]          w_onehot;
  logic [N_DIGITS-1:0]          w_blank;

  scan_tick #(
    .PRESCALE (PRESCALE)
  ) u_scan_tick (
    .iClk  (iClk),
    .iRst  (iRst),
    .oTick (w_tick)
  );

  // The frame boundary is the tick that moves the index from the last digit
  // back to digit 0.
  assign w_wrap  = w_tick && (idx_q == C_LAST_IDX);
  assign frame_d = w_wrap;

  // Index, display, pending and flag next-state. The frame transfer is
  // evaluated before the load so that a load landing on the transfer cycle
  // refills pending (and keeps the flag) while display takes the old word.
  always_comb begin
    idx_d  = idx_q;
    disp_d = disp_q;
    pend_d = pend_q;
    flag_d = flag_q;

    if (w_tick) begin
      idx_d = w_wrap ? '0 : (idx_q + IW'(1));
    end

    if (w_wrap && flag_q) begin
      disp_d = pend_q;
      flag_d = 1'b0;
    end

    if (iLoad) begin
      pend_d = iValue;
      flag_d = 1'b1;
    end
  end

  // Leading-zero blanking: digit k (k >= 1) goes dark when it and every
  // more-significant digit of the word being shown are zero. Each bit looks
  // at its own slice, so there is no ripple chain between bits.
`ifdef DIGIT_SCAN_LZB_EN
  assign w_blank[0] = 1'b0;
  for (genvar k = 1; k < N_DIGITS; k++) begin : g_blank
    assign w_blank[k] = (disp_d[N_DIGITS-1:k] == '0);
  end
`else
  assign w_blank = '0;
`endif

  // Code and enable for the slot that begins on the coming edge.
  always_comb begin
    w_onehot        = '0;
    w_onehot[idx_d] = 1'b1;
    an_d            = w_onehot & ~w_blank;
    code_d          = disp_d[idx_d];
  end

  // State and output registers; reset drops any in-flight pending word.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      idx_q   <= '0;
      disp_q  <= '0;
      pend_q  <= '0;
      flag_q  <= 1'b0;
      code_q  <= '0;
      an_q    <= C_AN_RST;
      frame_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      disp_q  <= disp_d;
      pend_q  <= pend_d;
      flag_q  <= flag_d;
      code_q  <= code_d;
      an_q    <= an_d;
      frame_q <= frame_d;
    end
  end

  assign {oW, oX, oY, oZ} = code_q;
  assign oAn              = an_q;
  assign oFrame           = frame_q;
  assign oPending         = flag_q;

endmodule
`default_nettype wire

// File: tb/tb_digit_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_digit_scan
//  Description : Self-checking bench for digit_scan (N_DIGITS=4, PRESCALE=4)
//                with an elapsed-time reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_digit_scan;

  localparam int N     = 4;
  localparam int P     = 4;
  localparam int FRAME = N * P;

  logic        iClk   = 1'b0;
  logic        iRst   = 1'b1;
  logic        iLoad  = 1'b0;
  logic [15:0] iValue = 16'h0000;
  logic        oW, oX, oY, oZ, oFrame, oPending;
  logic [3:0]  oAn;

  digit_scan #(
    .N_DIGITS (N),
    .PRESCALE (P)
  ) dut (
    .iClk     (iClk),
    .iRst     (iRst),
    .iLoad    (iLoad),
    .iValue   (iValue),
    .oW       (oW),
    .oX       (oX),
    .oY       (oY),
    .oZ       (oZ),
    .oAn      (oAn),
    .oFrame   (oFrame),
    .oPending (oPending)
  );

  always #5 iClk = ~iClk;

  int checks = 0;
  int errors = 0;

  // Reference model: time since reset decides the slot; words move at
  // every multiple of a frame.
  int          m_cnt  = 0;
  logic [15:0] m_disp = 16'h0;
  logic [15:0] m_pend = 16'h0;
  logic        m_flag = 1'b0;

  always @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      m_cnt  = 0;
      m_disp = 16'h0;
      m_pend = 16'h0;
      m_flag = 1'b0;
    end else begin
      if ((m_cnt % FRAME) == FRAME - 1 && m_flag) begin
        m_disp = m_pend;
        m_flag = 1'b0;
      end
      if (iLoad) begin
        m_pend = iValue;
        m_flag = 1'b1;
      end
      m_cnt = m_cnt + 1;
    end
  end

  function automatic int exp_idx();
    return (m_cnt / P) % N;
  endfunction

  function automatic logic [3:0] exp_code();
    return 4'((m_disp >> (4 * exp_idx())) & 16'hF);
  endfunction

  function automatic logic [3:0] exp_an();
    int i;
    i = exp_idx();
`ifdef DIGIT_SCAN_LZB_EN
    if (i > 0 && (m_disp >> (4 * i)) == 16'h0) return 4'b0000;
`endif
    return 4'(1 << i);
  endfunction

  function automatic logic exp_frame();
    return (m_cnt > 0) && ((m_cnt % FRAME) == 0);
  endfunction

  function automatic logic [9:0] exp_vec();
    return {exp_code(), exp_an(), exp_frame(), m_flag};
  endfunction

  wire [9:0] obs_vec = {oW, oX, oY, oZ, oAn, oFrame, oPending};
  wire [3:0] obs_code = {oW, oX, oY, oZ};

  // Stimulus helpers (no checking).
  task automatic align(input int k);
    for (int c = 0; c < 2 * FRAME && (m_cnt % FRAME) != k; c++) @(negedge iClk);
  endtask

  task automatic load(input logic [15:0] v);
    iLoad  = 1'b1;
    iValue = v;
    @(negedge iClk);
    iLoad  = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge iClk);
    iRst = 1'b1;
    repeat (2) @(negedge iClk);
    iRst = 1'b0;
  endtask

  task automatic test_reset();
    int cnt;
    iRst  = 1'b1;
    iLoad = 1'b0;
    repeat (2) @(negedge iClk);
    checks++;
    if (obs_vec !== 10'b0000_0001_0_0) begin
      errors++;
      $display("FAIL reset_hold: got %b expected %b", obs_vec, 10'b0000_0001_0_0);
    end
    iRst = 1'b0;
    load(16'hABCD);
    for (int c = 0; c < FRAME && exp_idx() != 2; c++) @(negedge iClk);
    checks++;
    if (oPending !== 1'b1 || oAn !== 4'b0100) begin
      errors++;
      $display("FAIL pre_reset_state: got pend=%b an=%b expected pend=1 an=0100", oPending, oAn);
    end
    #2 iRst = 1'b1;
    #1;
    checks++;
    if (obs_vec !== 10'b0000_0001_0_0) begin
      errors++;
      $display("FAIL async_reset: got %b expected %b", obs_vec, 10'b0000_0001_0_0);
    end
    @(negedge iClk);
    iRst = 1'b0;
    cnt  = 0;
    while (oAn == 4'b0001 && cnt < 20) begin
      @(negedge iClk);
      cnt++;
    end
    checks++;
    if (cnt != P) begin
      errors++;
      $display("FAIL first_tick: got %0d cycles expected %0d", cnt, P);
    end
  endtask

  task automatic test_scan_order();
    int last_frame;
    apply_reset();
    load(16'h4321);
    last_frame = -1;
    for (int c = 0; c < 3 * FRAME; c++) begin
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++;
        $display("FAIL scan_vec t=%0d: got %b expected %b", m_cnt, obs_vec, exp_vec());
      end
      if (m_cnt >= FRAME && m_cnt < 2 * FRAME && (m_cnt % P) == 0) begin
        checks++;
        if (obs_code !== 4'(exp_idx() + 1) || oAn !== 4'(1 << exp_idx())) begin
          errors++;
          $display("FAIL scan_slot %0d: got code=%h an=%b expected code=%h an=%b",
                   exp_idx(), obs_code, oAn, 4'(exp_idx() + 1), 4'(1 << exp_idx()));
        end
      end
      if (oFrame === 1'b1) begin
        if (last_frame >= 0) begin
          checks++;
          if (m_cnt - last_frame != FRAME) begin
            errors++;
            $display("FAIL frame_period: got %0d expected %0d", m_cnt - last_frame, FRAME);
          end
        end
        last_frame = m_cnt;
      end
      @(negedge iClk);
    end
  endtask

  task automatic test_no_tearing();
    align(P);
    load(16'h5678);
    for (int c = 0; c < FRAME && (m_cnt % FRAME) != 0; c++) begin
      checks++;
      if (obs_code !== 4'(exp_idx() + 1) || obs_vec !== exp_vec()) begin
        errors++;
        $display("FAIL no_tearing t=%0d: got code=%h vec=%b expected code=%h vec=%b",
                 m_cnt, obs_code, obs_vec, 4'(exp_idx() + 1), exp_vec());
      end
      @(negedge iClk);
    end
    checks++;
    if (obs_code !== 4'h8 || oPending !== 1'b0 || oFrame !== 1'b1) begin
      errors++;
      $display("FAIL tear_transfer: got code=%h pend=%b frame=%b expected 8 0 1",
               obs_code, oPending, oFrame);
    end
  endtask

  task automatic test_collision();
    logic [3:0] ed;
    logic       ep;
    align(2);
    load(16'h1111);
    align(FRAME - 1);
    load(16'h2222);
    for (int c = 0; c < 2 * FRAME; c++) begin
      ed = (c < FRAME) ? 4'h1 : 4'h2;
      ep = (c < FRAME) ? 1'b1 : 1'b0;
      checks++;
      if (obs_code !== ed || oPending !== ep || obs_vec !== exp_vec()) begin
        errors++;
        $display("FAIL collision c=%0d: got code=%h pend=%b expected code=%h pend=%b",
                 c, obs_code, oPending, ed, ep);
      end
      @(negedge iClk);
    end
  endtask

  task automatic test_blanking();
    logic [3:0] an_tab [4];
    logic [3:0] code_tab [4];
`ifdef DIGIT_SCAN_LZB_EN
    an_tab[0] = 4'b0001; an_tab[1] = 4'b0010; an_tab[2] = 4'b0000; an_tab[3] = 4'b0000;
`else
    an_tab[0] = 4'b0001; an_tab[1] = 4'b0010; an_tab[2] = 4'b0100; an_tab[3] = 4'b1000;
`endif
    code_tab[0] = 4'h0; code_tab[1] = 4'h5; code_tab[2] = 4'h0; code_tab[3] = 4'h0;
    align(1);
    load(16'h0050);
    align(0);
    for (int c = 0; c < FRAME; c++) begin
      checks++;
      if (oAn !== an_tab[c / P] || obs_code !== code_tab[c / P]) begin
        errors++;
        $display("FAIL blank_0050 slot %0d: got an=%b code=%h expected an=%b code=%h",
                 c / P, oAn, obs_code, an_tab[c / P], code_tab[c / P]);
      end
      @(negedge iClk);
    end
`ifdef DIGIT_SCAN_LZB_EN
    an_tab[1] = 4'b0000;
`endif
    align(1);
    load(16'h0000);
    align(0);
    for (int c = 0; c < FRAME; c++) begin
      checks++;
      if (oAn !== an_tab[c / P] || obs_code !== 4'h0) begin
        errors++;
        $display("FAIL blank_0000 slot %0d: got an=%b code=%h expected an=%b code=0",
                 c / P, oAn, obs_code, an_tab[c / P]);
      end
      @(negedge iClk);
    end
  endtask

  task automatic test_invalid();
    logic [3:0] code_tab [4];
    code_tab[0] = 4'h9; code_tab[1] = 4'h0; code_tab[2] = 4'hA; code_tab[3] = 4'hF;
    align(1);
    load(16'hFA09);
    align(0);
    for (int c = 0; c < FRAME; c++) begin
      checks++;
      if (obs_code !== code_tab[c / P] || obs_vec !== exp_vec()) begin
        errors++;
        $display("FAIL invalid_code slot %0d: got code=%h vec=%b expected code=%h vec=%b",
                 c / P, obs_code, obs_vec, code_tab[c / P], exp_vec());
      end
      @(negedge iClk);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++;
        $display("FAIL random t=%0d: got %b expected %b", m_cnt, obs_vec, exp_vec());
      end
      iLoad  = (($urandom % 6) == 0);
      iValue = 16'($urandom);
      if (($urandom % 4) == 0) iValue = iValue & 16'h00FF;
      @(negedge iClk);
    end
    iLoad = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_no_tearing();
    test_collision();
    test_blanking();
    test_invalid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
